// File: rtl/aes_dec_iter_core.sv
// aes_dec_iter_core: iterative AES inverse cipher. A single inverse-round
// datapath is stepped NR times per block between a valid/ready input stream
// and a valid/ready output stream. Round keys come from an external store
// that is read combinationally through rk_idx; the engine never holds a key.
// Optional feature macro: AES_DEC_ABORT_EN adds an abort input that drops the
// block in flight (ROUND or DONE) and returns the engine to IDLE.
module aes_dec_iter_core #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
`ifdef AES_DEC_ABORT_EN
  input  logic         abort,
`endif
  output logic [127:0] out_data,
  output logic         busy
);

  // Only the three AES key sizes are meaningful.
  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_dec_iter_core: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR_IDX   = 4'(NR);
  localparam logic [3:0] LAST_CNT = 4'(NR - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) begin
        acc = acc ^ aa;
      end else begin
        acc = acc;
      end
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Inverse S-box: undo the affine map, then invert in the field.
  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] u;
    u = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(u);
  endfunction

  // Row r of the state rotates right by r byte positions.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [7:0] b [16];
    for (int i = 0; i < 16; i++) begin
      b[i] = s[127-8*i -: 8];
    end
    return {b[0], b[13], b[10], b[7], b[4], b[1], b[14], b[11],
            b[8], b[5],  b[2], b[15], b[12], b[9], b[6], b[3]};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // One inverse round; the final round skips InvMixColumns.
  function automatic logic [127:0] inv_round(input logic [127:0] st,
                                             input logic [127:0] key,
                                             input logic         final_rnd);
    logic [127:0] x;
    logic [127:0] res;
    x = inv_shift_rows(st);
    for (int i = 0; i < 16; i++) begin
      x[127-8*i -: 8] = inv_sbox(x[127-8*i -: 8]);
    end
    x = x ^ key;
    if (final_rnd) begin
      res = x;
    end else begin
      for (int c = 0; c < 4; c++) begin
        res[127-32*c -: 32] = inv_mix_col(x[127-32*c -: 32]);
      end
    end
    return res;
  endfunction

  state_e       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [127:0] data_q, data_d;
  logic [127:0] out_data_q, out_data_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;
  logic [127:0] round_s;
  logic         abort_s;
  logic         abort_hit_s;

`ifdef AES_DEC_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  // Abort only matters while a block is held (ROUND or DONE).
  assign abort_hit_s = abort_s & (state_q != S_IDLE);
  assign round_s     = inv_round(data_q, rk, cnt_q == 4'd0);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;

  // Handshake and key-index outputs decoded from the current state.
  always_comb begin
    in_ready = 1'b0;
    rk_idx   = NR_IDX;
    case (state_q)
      S_IDLE:  in_ready = 1'b1;
      S_ROUND: rk_idx   = cnt_q;
      S_DONE:  in_ready = out_ready & ~abort_s;
      default: in_ready = 1'b0;
    endcase
  end

  // Next-state logic: load, round iteration, output hold and retire.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    if (abort_hit_s) begin
      // Drop the block; the last delivered plaintext stays on out_data.
      state_d     = S_IDLE;
      cnt_d       = LAST_CNT;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            data_d  = in_data ^ rk;
            cnt_d   = LAST_CNT;
            busy_d  = 1'b1;
            state_d = S_ROUND;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ROUND: begin
          data_d = round_s;
          if (cnt_q == 4'd0) begin
            out_data_d  = round_s;
            out_valid_d = 1'b1;
            busy_d      = 1'b0;
            state_d     = S_DONE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            if (in_valid) begin
              // Retire and accept on the same edge; rk_idx is NR here.
              data_d  = in_data ^ rk;
              cnt_d   = LAST_CNT;
              busy_d  = 1'b1;
              state_d = S_ROUND;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            state_d = S_DONE;
          end
        end
        default: begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= LAST_CNT;
      data_q      <= 128'h0;
      out_data_q  <= 128'h0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

endmodule

// File: tb/tb_aes_dec_iter_core.sv
// Bench for aes_dec_iter_core: three engines (NR = 10, 12, 14) fed from a
// bench-side key schedule, checked by a scoreboard against an AES reference.
module tb_aes_dec_iter_core;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         in_valid_a  [3];
  logic         in_ready_a  [3];
  logic [127:0] in_data_a   [3];
  logic [3:0]   rk_idx_a    [3];
  logic [127:0] rk_a        [3];
  logic         out_valid_a [3];
  logic         out_ready_a [3];
  logic [127:0] out_data_a  [3];
  logic         busy_a      [3];
`ifdef AES_DEC_ABORT_EN
  logic         abort_a     [3];
`endif

  logic [7:0]   sbox [256];
  logic [7:0]   isb  [256];
  logic [127:0] ks   [3][16];

  int errors = 0;
  int checks = 0;
  logic [31:0] cyc = 32'd0;

  typedef struct packed {
    logic [1:0]   inst;
    logic [127:0] pt;
    logic [31:0]  acc;
  } exp_t;
  exp_t sb[$];

  int   busy_cnt [3];
  logic prev_ov  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_dec_iter_core #(.NR(10 + 2*g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_a[g]),
      .in_ready  (in_ready_a[g]),
      .in_data   (in_data_a[g]),
      .rk_idx    (rk_idx_a[g]),
      .rk        (rk_a[g]),
      .out_valid (out_valid_a[g]),
      .out_ready (out_ready_a[g]),
`ifdef AES_DEC_ABORT_EN
      .abort     (abort_a[g]),
`endif
      .out_data  (out_data_a[g]),
      .busy      (busy_a[g])
    );
    // Combinational key store read.
    assign rk_a[g] = ks[g][rk_idx_a[g]];
  end

  // Cycle counter for latency measurement.
  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, p;
    r = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xt(p);
    end
    return r;
  endfunction

  // Forward S-box by walking the field with generator 3, then invert it.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
    for (int i = 0; i < 256; i++) isb[sbox[i]] = 8'(i);
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  // FIPS-197 key expansion into ks[g][0..nr]; key is left-aligned.
  task automatic expand(input int g, input logic [255:0] key, input int nr);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk;
    nk = nr - 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) ks[g][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Reference inverse cipher on a byte matrix (byte r + 4c = row r, column c).
  function automatic logic [127:0] model_dec(input int g, input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] blk;
    int nr;
    nr  = 10 + 2*g;
    blk = ct ^ ks[g][nr];
    for (int rnd = nr - 1; rnd >= 0; rnd--) begin
      for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r+4*c] = isb[s[r + 4*((c - r + 4) % 4)]];
      for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = t[i];
      blk = blk ^ ks[g][rnd];
      if (rnd > 0) begin
        for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++)
            t[r+4*c] = gm(s[4*c+r], 8'h0e) ^ gm(s[4*c+(r+1)%4], 8'h0b) ^
                       gm(s[4*c+(r+2)%4], 8'h0d) ^ gm(s[4*c+(r+3)%4], 8'h09);
        for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = t[i];
      end
    end
    return blk;
  endfunction

  function automatic int find_inst(input int g);
    for (int i = 0; i < sb.size(); i++)
      if (sb[i].inst == 2'(g)) return i;
    return -1;
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    int idx;
    int nr;
    if (!rst_n) begin
      sb.delete();
      for (int g = 0; g < 3; g++) begin
        busy_cnt[g] = 0;
        prev_ov[g]  = 1'b0;
      end
    end else begin
      for (int g = 0; g < 3; g++) begin
        nr = 10 + 2*g;
        if (busy_a[g]) begin
          busy_cnt[g]++;
          chk("rk_idx_round", 128'(rk_idx_a[g]), 128'(nr - busy_cnt[g]));
        end else begin
          chk("rk_idx_idle", 128'(rk_idx_a[g]), 128'(nr));
        end
`ifdef AES_DEC_ABORT_EN
        if (abort_a[g] && (busy_a[g] || out_valid_a[g])) begin
          idx = find_inst(g);
          if (idx >= 0) sb.delete(idx);
          busy_cnt[g] = 0;
          prev_ov[g]  = out_valid_a[g];
          continue;
        end
`endif
        if (out_valid_a[g] && !prev_ov[g]) begin
          idx = find_inst(g);
          chk("valid_has_expected", 128'(idx >= 0), 128'd1);
          if (idx >= 0) begin
            chk("latency", 128'(cyc - sb[idx].acc), 128'(nr + 1));
            chk("busy_cycles", 128'(busy_cnt[g]), 128'(nr));
          end
          busy_cnt[g] = 0;
        end
        if (out_valid_a[g] && out_ready_a[g]) begin
          idx = find_inst(g);
          chk("retire_has_expected", 128'(idx >= 0), 128'd1);
          if (idx >= 0) begin
            chk("out_data", out_data_a[g], sb[idx].pt);
            sb.delete(idx);
          end
        end
        if (in_valid_a[g] && in_ready_a[g])
          sb.push_back({2'(g), model_dec(g, in_data_a[g]), cyc});
        prev_ov[g] = out_valid_a[g];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one block for a single cycle (engine assumed ready).
  task automatic send(input int g, input logic [127:0] d);
    step();
    in_valid_a[g] = 1'b1;
    in_data_a[g]  = d;
    step();
    in_valid_a[g] = 1'b0;
  endtask

  // Wait on the falling edge for out_valid, bounded by lim cycles.
  task automatic wait_ov(input int g, input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (out_valid_a[g]) break;
    end
    chk("out_valid_wait", 128'(out_valid_a[g]), 128'd1);
  endtask

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  initial begin
    logic [127:0] blk_a, blk_b, exp_a;
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      in_valid_a[g]  = 1'b0;
      in_data_a[g]   = 128'h0;
      out_ready_a[g] = 1'b1;
`ifdef AES_DEC_ABORT_EN
      abort_a[g]     = 1'b0;
`endif
    end
    build_sbox();
    expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 10);
    expand(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 12);
    expand(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 14);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("rst_out_valid", 128'(out_valid_a[g]), 128'd0);
      chk("rst_out_data", out_data_a[g], 128'h0);
      chk("rst_busy", 128'(busy_a[g]), 128'd0);
      chk("rst_in_ready", 128'(in_ready_a[g]), 128'd1);
    end

    // Known-answer vectors for each key size.
    send(0, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    wait_ov(0, 20);
    chk("kat_nr10", out_data_a[0], PT);
    send(1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    wait_ov(1, 20);
    chk("kat_nr12", out_data_a[1], PT);
    send(2, 128'h8ea2b7ca516745bfeafc49904b496089);
    wait_ov(2, 20);
    chk("kat_nr14", out_data_a[2], PT);
    step();

    // Back-pressure: output held, input blocked, then retire+accept together.
    blk_a = {$urandom, $urandom, $urandom, $urandom};
    blk_b = {$urandom, $urandom, $urandom, $urandom};
    exp_a = model_dec(0, blk_a);
    out_ready_a[0] = 1'b0;
    send(0, blk_a);
    wait_ov(0, 20);
    repeat (5) begin
      step();
      in_valid_a[0] = 1'b1;
      in_data_a[0]  = blk_b;
      @(negedge clk);
      chk("bp_out_valid", 128'(out_valid_a[0]), 128'd1);
      chk("bp_out_data", out_data_a[0], exp_a);
      chk("bp_in_ready", 128'(in_ready_a[0]), 128'd0);
    end
    step();
    out_ready_a[0] = 1'b1;
    @(negedge clk);
    chk("b2b_in_ready", 128'(in_ready_a[0]), 128'd1);
    step();
    in_valid_a[0] = 1'b0;
    wait_ov(0, 20);
    chk("b2b_second", out_data_a[0], model_dec(0, blk_b));
    step();

    // Reset during round 5 discards the block.
    send(0, {$urandom, $urandom, $urandom, $urandom});
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", 128'(out_valid_a[0]), 128'd0);
    chk("mid_rst_out_data", out_data_a[0], 128'h0);
    chk("mid_rst_in_ready", 128'(in_ready_a[0]), 128'd1);
    chk("mid_rst_busy", 128'(busy_a[0]), 128'd0);
    blk_a = {$urandom, $urandom, $urandom, $urandom};
    send(0, blk_a);
    wait_ov(0, 20);
    chk("post_rst_block", out_data_a[0], model_dec(0, blk_a));
    step();

    // Random traffic on all engines; engine 0 gets a fresh random key.
    expand(0, {$urandom, $urandom, $urandom, $urandom, 128'h0}, 10);
    for (int i = 0; i < 1500; i++) begin
      step();
      for (int g = 0; g < 3; g++) begin
        in_valid_a[g]  = ($urandom_range(0, 9) < 6);
        in_data_a[g]   = {$urandom, $urandom, $urandom, $urandom};
        out_ready_a[g] = ($urandom_range(0, 9) < 6);
      end
    end
    step();
    for (int g = 0; g < 3; g++) begin
      in_valid_a[g]  = 1'b0;
      out_ready_a[g] = 1'b1;
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    chk("drain_empty", 128'(sb.size()), 128'd0);

`ifdef AES_DEC_ABORT_EN
    // Abort in round 3: block dropped, no output.
    step();
    send(0, {$urandom, $urandom, $urandom, $urandom});
    repeat (2) step();
    abort_a[0] = 1'b1;
    step();
    abort_a[0] = 1'b0;
    @(negedge clk);
    chk("abort_rnd_busy", 128'(busy_a[0]), 128'd0);
    chk("abort_rnd_in_ready", 128'(in_ready_a[0]), 128'd1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("abort_rnd_no_valid", 128'(out_valid_a[0]), 128'd0);
    end
    // Abort in DONE wins over out_ready and in_valid.
    blk_a = {$urandom, $urandom, $urandom, $urandom};
    exp_a = model_dec(0, blk_a);
    out_ready_a[0] = 1'b0;
    send(0, blk_a);
    wait_ov(0, 20);
    chk("abort_done_data", out_data_a[0], exp_a);
    step();
    abort_a[0]     = 1'b1;
    out_ready_a[0] = 1'b1;
    in_valid_a[0]  = 1'b1;
    in_data_a[0]   = {$urandom, $urandom, $urandom, $urandom};
    step();
    abort_a[0]    = 1'b0;
    in_valid_a[0] = 1'b0;
    @(negedge clk);
    chk("abort_done_valid", 128'(out_valid_a[0]), 128'd0);
    chk("abort_done_busy", 128'(busy_a[0]), 128'd0);
    chk("abort_done_keep", out_data_a[0], exp_a);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("abort_done_no_valid", 128'(out_valid_a[0]), 128'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_dec_iter_core.md
# aes_dec_iter_core

Iterative AES inverse-cipher engine, parametrised over key size (NR = 10/12/14 rounds), processing one 128-bit block per NR+1 cycles through a single shared inverse-round datapath. Sits between the block-level input/output valid/ready streams and the team's round-key store, which it addresses by round index. It generalises the single combinational inverse round (InvShiftRows → InvSubBytes → AddRoundKey → InvMixColumns, MixColumns skipped in the last round) into a sequenced engine with handshakes, round counter and back-to-back block acceptance.

## Interface
- NR, 10, number of rounds; legal values 10, 12, 14 only (other values: elaboration error)
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  ciphertext block offered
- in_ready  output  1  engine can accept a block this cycle
- in_data  input  128  ciphertext, byte 0 in [127:120]
- rk_idx  output  4  round-key index requested (0..NR)
- rk  input  128  round key for rk_idx, valid in the same cycle (combinational key store read)
- out_valid  output  1  plaintext available
- out_ready  input  1  consumer accepts plaintext
- out_data  output  128  plaintext, same byte order
- busy  output  1  high in ROUND state
- abort  input  1  present only with AES_DEC_ABORT_EN

## Operation
- Clock is clk; reset is rst_n, synchronous, active-low. Reset: state IDLE, round counter = NR-1, out_valid 0, out_data 0, busy 0.
- States: IDLE, ROUND, DONE.
- IDLE: in_ready 1, rk_idx = NR. On in_valid: data_reg ← in_data ^ rk; cnt ← NR-1; → ROUND.
- ROUND: rk_idx = cnt; data_reg ← inv_round(data_reg, rk, final = (cnt == 0)). inv_round = InvShiftRows, InvSubBytes, XOR rk, then InvMixColumns unless final. cnt decrements; at cnt == 0 the result goes to out_data, out_valid ← 1, → DONE. in_ready 0, in_valid ignored.
- DONE: out_valid held 1, out_data stable until out_ready. rk_idx = NR. in_ready = out_ready.
  - out_ready & !in_valid: out_valid ← 0, → IDLE.
  - out_ready & in_valid: output retired and new block accepted same edge (load as IDLE); → ROUND; out_valid ← 0.
  - !out_ready: stay; in_valid ignored.
- Key store is read every cycle; engine never registers rk.
- Reset asserted mid-block discards the block; no partial output.

## Timing
- Accept at edge k (in_valid & in_ready high in preceding cycle). Rounds at edges k+1 … k+NR. out_valid high from edge k+NR.
- Latency in → out_valid: NR+1 cycles (11 for NR=10). Throughput with out_ready held high: one block per NR+1 cycles.
- rk_idx sequence for one block: NR, NR-1, …, 1, 0.
- busy high exactly NR cycles per block.
- in_ready is combinational from state and out_ready; out_valid, out_data, busy registered.

## Configuration
- AES_DEC_ABORT_EN defined: abort input exists. abort high in ROUND or DONE → next edge IDLE, out_valid 0, out_data unchanged, block dropped; abort in IDLE has no effect; abort has priority over out_ready and in_valid on the same edge.
- Undefined: no abort port; every accepted block completes.

## Test plan
- NR=10, FIPS-197 C.1 keys (key 000102030405060708090a0b0c0d0e0f), in_data 69c4e0d86a7b0430d8cdb78070b4c55a, out_ready 1 → out_data 00112233445566778899aabbccddeeff, out_valid first high 11 cycles after accept, rk_idx 10,9,…,0.
- NR=14, C.3 keys (000102…1f), in_data 8ea2b7ca516745bfeafc49904b496089 → 00112233445566778899aabbccddeeff after 15 cycles; NR=12 C.2 vector dd a97ca4864cdfe06eaf70a0ec0d7191 → same plaintext after 13 cycles.
- Back-pressure: out_ready 0 for 5 cycles after out_valid → out_data stable, in_ready 0, second in_valid ignored; out_ready 1 with in_valid 1 → retire and accept same edge, second block out 11 cycles later.
- Reset: rst_n low at round 5 for 1 cycle → out_valid 0, out_data 0, in_ready 1 next cycle; next block decrypts correctly.
- AES_DEC_ABORT_EN: abort at round 3 → IDLE next edge, no out_valid; abort with out_ready & in_valid in DONE → no new accept, IDLE.
